// File: rtl/ysyx_24090003_lsu.sv
// Load-store unit: one EXU request at a time, issued as a word-aligned byte-strobed memory
// transaction; load data comes back aligned and extended, errors and timeouts flagged on resp_err.
module ysyx_24090003_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        cpu_clk,
   input  logic        cpu_rs,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   input  logic        mem_rsp_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        wen_q, wen_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  funct_q, funct_d;
   logic [15:0] cnt_q, cnt_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        req_illegal;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] ld_shift;
   logic [31:0] ld_data;

   always_comb begin
      req_illegal = 1'b0;
      case (req_funct)
         3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
         3'b001, 3'b101:         req_illegal = req_addr[0];
         3'b010:                 req_illegal = (req_addr[1:0] != 2'b00);
         default:                req_illegal = 1'b0;
      endcase
      if (req_wen && req_funct[2]) req_illegal = 1'b1;
   end

   always_comb begin
      st_wdata = req_wdata;
      st_wstrb = 4'b1111;
      case (req_funct[1:0])
         2'b00: begin
            st_wdata = {4{req_wdata[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{req_wdata[15:0]}};
            st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = req_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   // Byte lane of interest is moved to bit 0 before extension.
   assign ld_shift = mem_rsp_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_data = ld_shift;
      case (funct_q)
         3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_data = {24'b0, ld_shift[7:0]};
         3'b101:  ld_data = {16'b0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      off_d       = off_q;
      funct_d     = funct_q;
      cnt_d       = cnt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wen_d   = req_wen;
               off_d   = req_addr[1:0];
               funct_d = req_funct;
               if (req_illegal) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else begin
                  state_d     = REQ;
                  mem_we_d    = req_wen;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_wdata_d = req_wen ? st_wdata : 32'h0;
                  mem_wstrb_d = req_wen ? st_wstrb : 4'b0000;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d     = WAIT;
               cnt_d       = 16'h0;
               mem_we_d    = 1'b0;
               mem_addr_d  = 32'h0;
               mem_wdata_d = 32'h0;
               mem_wstrb_d = 4'b0000;
            end
         end
         WAIT: begin
            // A response in the final counted cycle beats the timeout.
            if (mem_rsp_valid) begin
               state_d = RESP;
               err_d   = mem_rsp_err;
               rdata_d = (mem_rsp_err || wen_q) ? 32'h0 : ld_data;
            end else if (cnt_q == TO_LAST) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 16'h1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               err_d   = 1'b0;
               rdata_d = 32'h0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rs) begin
      if (cpu_rs) begin
         state_q     <= IDLE;
         wen_q       <= 1'b0;
         off_q       <= 2'b00;
         funct_q     <= 3'b000;
         cnt_q       <= 16'h0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'b0000;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         off_q       <= off_d;
         funct_q     <= funct_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign mem_req_valid = (state_q == REQ);
   assign resp_valid    = (state_q == RESP);
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wstrb     = mem_wstrb_q;
   assign resp_rdata    = rdata_q;
   assign resp_err      = err_q;

endmodule

// File: doc/ysyx_24090003_lsu.md
Name: ysyx_24090003_lsu

Overview:
Load-store unit downstream of the EXU. It takes one memory request per handshake (address, store data, funct3) from the execution stage and issues a word-aligned, byte-strobed transaction to the data memory port. It returns load data aligned and extended, or a store completion, through a valid/ready response channel. Misaligned and illegal requests, memory errors and memory timeouts are reported as errors.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT before the transaction is aborted with error (1..65535)

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rs  in  1  reset, asynchronous, active-high
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for SB/SH)
req_funct  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
resp_valid  out  1  response valid
resp_ready  in  1  EXU/WB accepts response
resp_rdata  out  32  load result (0 for stores and errors)
resp_err  out  1  misaligned, illegal, bus error or timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  32  req_addr with [1:0] forced to 00
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes (0000 for loads)
mem_rsp_valid  in  1  memory response valid (single-cycle pulse)
mem_rsp_rdata  in  32  read word
mem_rsp_err  in  1  bus error with response

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset (async, any time) forces IDLE and clears all registers. Outputs during and after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- req_ready=1 only in IDLE. All other outputs are registered or decoded from registered state.
- IDLE: on req_valid&req_ready, latch wen/addr/wdata/funct.
  - Error, go to RESP with resp_err=1, resp_rdata=0, no memory access: funct 011/110/111; store with funct[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=00.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1. mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until mem_req_ready=1, then go to WAIT and clear the timeout counter.
  - mem_rsp_valid is ignored in REQ.
- Store formatting:
  - SB: wdata={4{wdata[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wdata=wdata, wstrb=1111.
- WAIT: counter increments each cycle.
  - On mem_rsp_valid: resp_err=mem_rsp_err; resp_rdata=formatted data (0 if err or store); go to RESP.
  - Load formatting: shift mem_rsp_rdata right by 8*addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU); W passes through.
  - If the counter reaches TIMEOUT_CYCLES with no response: resp_err=1, resp_rdata=0, go to RESP.
  - If a response and the timeout occur in the same cycle, the response wins.
- RESP: resp_valid=1 with stable rdata/err until resp_ready=1, then go to IDLE (req_ready=1 next cycle). There is no IDLE->REQ bypass.
- Latency (request accepted at cycle N, zero-wait memory): mem_req_valid at N+1, accepted N+1, rsp N+2, resp_valid N+3. Error request: resp_valid at N+1.
- Late mem_rsp_valid arriving in IDLE, REQ or RESP (after timeout or reset) is dropped.
- Reset mid-transaction drops mem_req_valid immediately; the outstanding memory op is abandoned.

Test Plan:
- LW addr=0x80000010, mem returns 0xDEADBEEF one cycle after accept -> mem_addr=0x80000010, wstrb=0000, resp_rdata=0xDEADBEEF, err=0, resp_valid exactly 3 cycles after accept.
- LB addr=0x80000013 with rdata=0x80FF7F01 -> resp_rdata=0xFFFFFF80. LBU same -> 0x00000080. LH addr ...02 -> 0xFFFF80FF.
- SH addr=0x80000006, wdata=0x1234ABCD -> mem_wdata=0xABCDABCD, wstrb=1100, mem_we=1, resp_rdata=0, err=0.
- LW addr=0x80000002 -> no mem_req_valid, resp_valid next cycle, err=1. Store with funct=100 -> err=1.
- mem_req_ready held 0 for 5 cycles -> outputs stable throughout. With TIMEOUT_CYCLES=4 and no response -> err=1 after 4 WAIT cycles. A later rsp pulse in IDLE is ignored.
- Assert cpu_rs during WAIT -> mem_req_valid=0, resp_valid=0, req_ready=1 immediately. resp_ready held 0 for 3 cycles -> resp_valid/rdata held, req_ready=0.
